// File: rtl/div_seq_pkg.sv
// Shared types and constants for the divider request sequencer.
// The response struct widths here set the default TAG_W/OUTSIZE of the top.
package div_seq_pkg;

  localparam int DIV_LATENCY    = 6;
  localparam int DIV_TAG_W      = 4;
  localparam int DIV_OUTSIZE    = 20;
  localparam int DIV_FIFO_DEPTH = 8;

  typedef logic [DIV_TAG_W-1:0]   div_tag_t;
  typedef logic [DIV_OUTSIZE-1:0] div_quot_t;

  typedef struct packed {
    div_quot_t quot;
    div_tag_t  tag;
    logic      divzero;
  } div_rsp_t;

  // Saturation values for a zero denominator: largest positive / most negative quotient
  localparam div_quot_t DIV_SAT_POS = {1'b0, {(DIV_OUTSIZE-1){1'b1}}};
  localparam div_quot_t DIV_SAT_NEG = {1'b1, {(DIV_OUTSIZE-1){1'b0}}};

  function automatic div_quot_t div_sat_value(input logic num_neg);
    return num_neg ? DIV_SAT_NEG : DIV_SAT_POS;
  endfunction

endpackage

// File: rtl/div_rsp_fifo.sv
// Result FIFO for the divider sequencer: circular buffer with a registered head
// and registered occupancy count. Async active-high reset.
module div_rsp_fifo
  import div_seq_pkg::*;
#(
  parameter int DEPTH = DIV_FIFO_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  div_rsp_t                     wr_data,
  input  logic                         rd_en,
  output div_rsp_t                     head,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  div_rsp_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_next;
  logic             pop;
  div_rsp_t         head_next;

  assign head_valid  = (count != '0);
  assign pop         = rd_en & head_valid;
  assign rd_ptr_next = rd_ptr + PTR_W'(pop);
  assign count_next  = count + CNT_W'(wr_en) - CNT_W'(pop);

  // Next head entry; bypass the write when it lands in the slot that becomes the head
  always_comb begin
    head_next = '0;
    if (count_next != '0) begin
      if (wr_en && (wr_ptr == rd_ptr_next)) head_next = wr_data;
      else                                  head_next = mem[rd_ptr_next];
    end
  end

  // Storage array, no reset needed since reads are gated by the count
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers, count and registered head
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_en);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      head   <= head_next;
    end
  end

  // Credit-based issue makes a write into a full FIFO impossible
  assert property (@(posedge clock) disable iff (reset) !(wr_en && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/div_request_sequencer.sv
// Front-end for a fixed-latency pipelined divider: accepts tagged requests,
// tracks them through the divider latency and buffers tagged quotients.
// Optional feature macro: DIV_SEQ_DIVZERO_SAT_EN (saturate on zero denominator).
module div_request_sequencer
  import div_seq_pkg::*;
#(
  parameter int LATENCY    = DIV_LATENCY,
  parameter int TAG_W      = DIV_TAG_W,
  parameter int FIFO_DEPTH = DIV_FIFO_DEPTH,
  parameter int OUTSIZE    = DIV_OUTSIZE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_num,
  input  logic [21:0]        req_den,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [31:0]        div_numerator,
  output logic [21:0]        div_denominator,
  input  logic [OUTSIZE-1:0] div_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [OUTSIZE-1:0] rsp_quot,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_divzero,
  output logic               busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic               issue;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     credit_used;
  logic [LATENCY-1:0] pipe_valid;
  div_tag_t           pipe_tag [LATENCY];
  logic               tail_valid;
  div_rsp_t           tail_rsp;
  div_rsp_t           head_rsp;

`ifdef DIV_SEQ_DIVZERO_SAT_EN
  logic [LATENCY-1:0] pipe_dz;
  logic [LATENCY-1:0] pipe_sign;
`endif

  // Credits come only from registered counts, so rsp_ready never reaches req_ready
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign req_ready   = (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign issue       = req_valid & req_ready;

  // Idle operands are 0/1 so the divider never sees X or a zero denominator
  assign div_numerator   = issue ? req_num : 32'd0;
  assign div_denominator = issue ? req_den : 22'd1;

  assign tail_valid = pipe_valid[LATENCY-1];

  // Valid/tag pipe mirrors the divider latency so the tail lines up with div_result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_valid  <= {pipe_valid[LATENCY-2:0], issue};
      pipe_tag[0] <= req_tag;
      for (int i = 1; i < LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

`ifdef DIV_SEQ_DIVZERO_SAT_EN
  // Zero-denominator flag and numerator sign travel alongside the valid bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_dz   <= '0;
      pipe_sign <= '0;
    end else begin
      pipe_dz   <= {pipe_dz[LATENCY-2:0], issue & (req_den == 22'd0)};
      pipe_sign <= {pipe_sign[LATENCY-2:0], req_num[31]};
    end
  end
`endif

  // Pair the returning quotient with its tag; saturate zero-denominator results when enabled
  always_comb begin
    tail_rsp      = '0;
    tail_rsp.quot = div_result;
    tail_rsp.tag  = pipe_tag[LATENCY-1];
`ifdef DIV_SEQ_DIVZERO_SAT_EN
    if (pipe_dz[LATENCY-1]) begin
      tail_rsp.quot    = div_sat_value(pipe_sign[LATENCY-1]);
      tail_rsp.divzero = 1'b1;
    end
`endif
  end

  // In-flight counter: +1 on issue, -1 when the tail retires into the FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) inflight <= '0;
    else       inflight <= inflight + CNT_W'(issue) - CNT_W'(tail_valid);
  end

  div_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (tail_valid),
    .wr_data    (tail_rsp),
    .rd_en      (rsp_ready),
    .head       (head_rsp),
    .head_valid (rsp_valid),
    .count      (fifo_count)
  );

  assign rsp_quot    = head_rsp.quot;
  assign rsp_tag     = head_rsp.tag;
  assign rsp_divzero = head_rsp.divzero;
  assign busy        = (inflight != '0) | (fifo_count != '0);

endmodule

// File: tb/tb_div_request_sequencer.sv
// Bench for div_request_sequencer: includes a fixed-latency divider model and
// a queue-based reference of issue/credit/ordering behaviour.
module tb_div_request_sequencer;

  localparam int LAT   = 6;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_num;
  logic [21:0] req_den;
  logic [3:0]  req_tag;
  logic [31:0] div_numerator;
  logic [21:0] div_denominator;
  logic [19:0] div_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [19:0] rsp_quot;
  logic [3:0]  rsp_tag;
  logic        rsp_divzero;
  logic        busy;

  div_request_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_num         (req_num),
    .req_den         (req_den),
    .req_tag         (req_tag),
    .div_numerator   (div_numerator),
    .div_denominator (div_denominator),
    .div_result      (div_result),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_quot        (rsp_quot),
    .rsp_tag         (rsp_tag),
    .rsp_divzero     (rsp_divzero),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  // Divider semantics: truncating signed divide, low 20 bits; arbitrary value for den 0
  function automatic logic [19:0] ref_div(input logic [31:0] n, input logic [21:0] d);
    logic signed [31:0] sn;
    logic signed [31:0] sd;
    logic signed [31:0] q;
    if (d == 22'd0) return 20'h5A5A5;
    sn = n;
    sd = {{10{d[21]}}, d};
    q  = sn / sd;
    return q[19:0];
  endfunction

  logic [19:0] dv_pipe [LAT];
  initial for (int i = 0; i < LAT; i++) dv_pipe[i] = '0;
  always @(posedge clock) begin
    dv_pipe[0] <= ref_div(div_numerator, div_denominator);
    for (int i = 1; i < LAT; i++) dv_pipe[i] <= dv_pipe[i-1];
  end
  assign div_result = dv_pipe[LAT-1];

  typedef struct {
    logic [19:0] q;
    logic [3:0]  tag;
    logic        dz;
    int          arrive;
  } exp_t;

  exp_t pend[$];
  exp_t fifo_q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   n_accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  function automatic void model_result(input logic [31:0] n, input logic [21:0] d,
                                       output logic [19:0] q, output logic dz);
    dz = 1'b0;
    q  = ref_div(n, d);
`ifdef DIV_SEQ_DIVZERO_SAT_EN
    if (d == 22'd0) begin
      dz = 1'b1;
      q  = n[31] ? 20'h80000 : 20'h7FFFF;
    end
`endif
  endfunction

  function automatic logic model_ready();
    return (pend.size() + fifo_q.size()) < DEPTH;
  endfunction

  task automatic check_outputs();
    chk("req_ready", 32'(req_ready), 32'(model_ready()));
    chk("busy", 32'(busy), 32'((pend.size() + fifo_q.size()) != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) begin
      chk("rsp_quot", 32'(rsp_quot), 32'(fifo_q[0].q));
      chk("rsp_tag", 32'(rsp_tag), 32'(fifo_q[0].tag));
      chk("rsp_divzero", 32'(rsp_divzero), 32'(fifo_q[0].dz));
    end
  endtask

  // One clock cycle: compare, drive, advance the model across the edge
  task automatic step(input logic rv, input logic [31:0] n, input logic [21:0] d,
                      input logic [3:0] t, input logic rr);
    logic iss;
    exp_t e;
    check_outputs();
    req_valid = rv; req_num = n; req_den = d; req_tag = t; rsp_ready = rr;
    #1;
    iss = rv && model_ready();
    chk("div_numerator", div_numerator, iss ? n : 32'd0);
    chk("div_denominator", 32'(div_denominator), iss ? 32'(d) : 32'd1);
    if (rr && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (pend.size() != 0 && pend[0].arrive == cyc) fifo_q.push_back(pend.pop_front());
    if (iss) begin
      model_result(n, d, e.q, e.dz);
      e.tag    = t;
      e.arrive = cyc + LAT;
      pend.push_back(e);
      n_accepted++;
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle(input int cycles, input logic rr);
    for (int i = 0; i < cycles; i++) step(1'b0, 32'd0, 22'd0, 4'd0, rr);
  endtask

  task automatic mid_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    pend.delete();
    fifo_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cyc++;
  endtask

  initial begin
    logic [31:0] rn;
    logic [21:0] rd;
    int          p_rdy;

    reset = 1'b1; req_valid = 1'b0; req_num = '0; req_den = '0; req_tag = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("init_rsp_quot", 32'(rsp_quot), 32'd0);
    chk("init_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("init_rsp_divzero", 32'(rsp_divzero), 32'd0);
    chk("init_req_ready", 32'(req_ready), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);

    // Single request 100/7 tag 3: rsp_valid exactly LAT+1 cycles after issue
    step(1'b1, 32'd100, 22'd7, 4'd3, 1'b1);
    for (int i = 0; i < LAT; i++) begin
      chk("single_not_early", 32'(rsp_valid), 32'd0);
      step(1'b0, 32'd0, 22'd0, 4'd0, 1'b1);
    end
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_quot", 32'(rsp_quot), 32'd14);
    chk("single_tag", 32'(rsp_tag), 32'd3);
    chk("single_dz", 32'(rsp_divzero), 32'd0);
    idle(3, 1'b1);

    // Signed operands, truncation toward zero
    step(1'b1, -32'sd100, 22'd7, 4'd1, 1'b0);
    step(1'b1, 32'd100, -22'sd7, 4'd2, 1'b0);
    idle(LAT + 1, 1'b0);
    chk("neg_num_quot", 32'(rsp_quot), 32'h000FFFF2);
    step(1'b0, 32'd0, 22'd0, 4'd0, 1'b1);
    chk("neg_den_quot", 32'(rsp_quot), 32'h000FFFF2);
    chk("neg_den_tag", 32'(rsp_tag), 32'd2);
    idle(3, 1'b1);

`ifdef DIV_SEQ_DIVZERO_SAT_EN
    step(1'b1, 32'd5, 22'd0, 4'd4, 1'b0);
    step(1'b1, -32'sd5, 22'd0, 4'd5, 1'b0);
    idle(LAT + 1, 1'b0);
    chk("sat_pos_quot", 32'(rsp_quot), 32'h0007FFFF);
    chk("sat_pos_dz", 32'(rsp_divzero), 32'd1);
    step(1'b0, 32'd0, 22'd0, 4'd0, 1'b1);
    chk("sat_neg_quot", 32'(rsp_quot), 32'h00080000);
    chk("sat_neg_dz", 32'(rsp_divzero), 32'd1);
    idle(3, 1'b1);
`endif

    // Fill with backpressure: 12 offered, 8 accepted, then drain in tag order
    n_accepted = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 32'(1000 + i), 22'd3, 4'(i), 1'b0);
    chk("fill_accepted", 32'(n_accepted), 32'd8);
    idle(8, 1'b0);
    chk("fill_req_ready_low", 32'(req_ready), 32'd0);
    chk("fill_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("drain_tag", 32'(rsp_tag), 32'(i));
      step(1'b0, 32'd0, 22'd0, 4'd0, 1'b1);
      if (i == 0) chk("ready_after_first_pop", 32'(req_ready), 32'd1);
    end
    chk("drain_empty", 32'(rsp_valid), 32'd0);

    // Full throughput with rsp_ready held high
    n_accepted = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 32'(i * 37), 22'(i + 1), 4'(i), 1'b1);
    chk("stream_accepted", 32'(n_accepted), 32'd40);
    idle(LAT + 3, 1'b1);

    // Reset mid-operation discards everything in flight
    for (int i = 0; i < 4; i++) step(1'b1, 32'(50 + i), 22'd5, 4'(i), 1'b0);
    idle(3, 1'b0);
    mid_reset();
    for (int i = 0; i < 12; i++) begin
      chk("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
      step(1'b0, 32'd0, 22'd0, 4'd0, 1'b1);
    end

    // Randomized traffic with varying consumer backpressure
    for (int seg = 0; seg < 20; seg++) begin
      p_rdy = (seg % 3 == 0) ? 15 : ((seg % 3 == 1) ? 50 : 95);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 1) == 0) rn = 32'($urandom_range(0, 4000)) - 32'd2000;
        else rn = $urandom();
        if (rn == 32'h80000000) rn = 32'd0;
        case ($urandom_range(0, 7))
          0:       rd = 22'd0;
          1, 2:    rd = 22'($urandom_range(0, 40)) - 22'd20;
          default: rd = 22'($urandom());
        endcase
        step($urandom_range(0, 99) < 70, rn, rd, 4'($urandom()),
             $urandom_range(0, 99) < p_rdy);
      end
    end
    idle(LAT + DEPTH + 2, 1'b1);
    chk("final_idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_request_sequencer.md
Name: div_request_sequencer

Overview:
- Front-end for the fixed-latency pipelined divider (no valid/ready of its own) used by GPU setup (slope/interpolant divides).
- Accepts tagged divide requests through a valid/ready handshake and issues at most one per cycle to the divider.
- Tracks each request through the divider latency and pairs the returned quotient with its tag.
- Buffers results in an output FIFO with backpressure; credit-based issue guarantees no result is ever dropped.

Parameters:
LATENCY, 6, clock edges from divider input sample to valid quotient; must match the divider instance
TAG_W, 4, request tag width
FIFO_DEPTH, 8, result FIFO entries (power of two, >= 2)
OUTSIZE, 20, quotient width delivered to the consumer

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when req_valid is also high
req_num  in  32  signed numerator
req_den  in  22  signed denominator
req_tag  in  TAG_W  opaque tag returned with the result
div_numerator  out  32  to divider numerator
div_denominator  out  22  to divider denominator
div_result  in  OUTSIZE  divider quotient, low OUTSIZE bits
rsp_valid  out  1  result available at FIFO head
rsp_ready  in  1  consumer pops the head when rsp_valid is high
rsp_quot  out  OUTSIZE  signed quotient
rsp_tag  out  TAG_W  tag of the head result
rsp_divzero  out  1  head result came from a zero denominator
busy  out  1  any request in flight or buffered

Behaviour:
- Reset (async assert, sync release): valid pipe cleared, FIFO empty, inflight=0; req_ready=1, rsp_valid=0, rsp_quot=0, rsp_tag=0, rsp_divzero=0, busy=0.
- Issue:
  - issue = req_valid & req_ready.
  - div_numerator/div_denominator = req_num/req_den when issue, else 0/1 (never feeds X or a zero denominator while idle).
- Credit rule:
  - inflight + fifo_count <= FIFO_DEPTH at all times.
  - req_ready = (inflight + fifo_count < FIFO_DEPTH), computed from registered counts only; no combinational path from rsp_ready.
- Tracking:
  - A LATENCY-deep shift register carries {valid, tag, divzero, num_sign}.
  - A request issued in cycle t reaches the tail in cycle t+LATENCY.
  - In that cycle div_result belongs to it; {quot, tag, divzero} is written into the FIFO at the end of cycle t+LATENCY.
- Counters:
  - inflight +1 on issue, -1 on tail-valid.
  - fifo_count +1 on tail write, -1 on pop.
  - Simultaneous events net out within the same cycle.
- Full/empty:
  - A tail write into a full FIFO is unreachable by the credit rule; assert it in simulation.
  - Pop with rsp_valid=0 is ignored.
- Ordering: strict FIFO order, so results return in issue order.
- Back-to-back: one issue per cycle sustained while credits remain; full throughput when rsp_ready is held high.
- Head outputs: rsp_quot/rsp_tag/rsp_divzero are registered, reflect the FIFO head, and hold steady while rsp_valid=1 and rsp_ready=0.
- Arithmetic: quotient is truncated toward zero (divider semantics); the block does not rescale.
- Reset mid-operation: all in-flight and buffered results are discarded; divider outputs arriving after reset are ignored because the valid pipe is cleared.
- busy = (inflight != 0) | (fifo_count != 0).

Optional Feature:
DIV_SEQ_DIVZERO_SAT_EN
- Defined:
  - req_den==0 sets the divzero bit in the pipe.
  - At the tail, the quotient is replaced by +(2^(OUTSIZE-1)-1) if the numerator is >= 0, else -(2^(OUTSIZE-1)).
  - rsp_divzero=1 for that entry.
- Undefined:
  - No divzero tracking; rsp_divzero is tied to 0.
  - The quotient passes div_result unmodified, including zero-denominator cases.

Decomposition:
- Package div_seq_pkg:
  - DIV_LATENCY constant (=6).
  - div_tag_t typedef.
  - div_rsp_t struct {quot, tag, divzero}.
  - Saturation constants derived from OUTSIZE.
- Sub-module div_rsp_fifo:
  - Synchronous FIFO of div_rsp_t, depth FIFO_DEPTH.
  - Registered head and count output.
  - Async active-high reset.

Test Plan:
- Single request num=100, den=7, tag=3, rsp_ready=1 -> rsp_valid rises exactly LATENCY+1 cycles after the issue cycle; rsp_quot=14, rsp_tag=3, rsp_divzero=0.
- num=-100, den=7 -> rsp_quot=-14 (0xFFFF2); num=100, den=-7 -> -14.
- rsp_ready=0, 12 requests offered back-to-back -> exactly 8 accepted, req_ready=0 thereafter, no loss. Release rsp_ready -> 8 results in tag order 0..7; req_ready reasserts the cycle after the first pop.
- Steady state with one issue and one pop per cycle at fifo_count=8-inflight -> counts stay constant, no assertion fires, order preserved.
- DIV_SEQ_DIVZERO_SAT_EN defined:
  - num=5, den=0 -> rsp_quot=0x7FFFF, rsp_divzero=1.
  - num=-5, den=0 -> 0x80000, rsp_divzero=1.
- Assert reset 3 cycles after issuing 4 requests -> no rsp_valid afterwards; busy=0 and req_ready=1 immediately after reset.
